// File: rtl/sha_unpad_pkg.sv
// ============================================================================
// Module  : sha_unpad_pkg
// Brief   : Shared widths, FSM state encoding, register record and byte
//           selection helper for the SHA unpadder. Optional macro
//           SHA_UNPAD_ERRCNT_EN adds the error-counter field.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package sha_unpad_pkg;

    localparam int NW       = 32;
    localparam int NB       = 16 * NW;
    localparam int NM       = 2 * NW;
    localparam int BPW      = NW / 8;
    localparam int BPW_BITS = $clog2(BPW);
    localparam int KW       = 4 + BPW_BITS;
    localparam int LMAX     = NB / 8 - 1 - NM / 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN   = 3'd1,
        CHECK = 3'd2,
        EMIT  = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } unpad_state_t;

    typedef struct packed {
        unpad_state_t    state;
        logic [NB-1:0]   block;
        logic [3:0]      w;
        logic [KW-1:0]   k;
        logic [NM-1:0]   length;
        logic            in_ready;
        logic [7:0]      msg_byte;
        logic            byte_valid;
        logic            done;
        logic            error;
`ifdef SHA_UNPAD_ERRCNT_EN
        logic [7:0]      err_count;
`endif
    } reg_type;

    // Byte 0 of each word sits in its most significant bits.
    function automatic logic [7:0] get_byte(input logic [NB-1:0] blk, input logic [KW-1:0] k);
        int unsigned off;
        off = 32'(k[KW-1:BPW_BITS]) * NW + (BPW - 1 - 32'(k[BPW_BITS-1:0])) * 8;
        return blk[off +: 8];
    endfunction

endpackage

`default_nettype wire

// File: rtl/sha_unpad_word_chk.sv
// ============================================================================
// Module  : sha_unpad_word_chk
// Brief   : Combinational check of one block word against the padding rule
//           (marker 0x80 at byte L, zeros after it, message bytes ignored).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sha_unpad_word_chk
    import sha_unpad_pkg::*;
(
    input  logic [NW-1:0] word,
    input  logic [3:0]    widx,
    input  logic [KW-1:0] len_bytes,
    output logic          ok
);

    logic [BPW-1:0] w_bad;

    for (genvar j = 0; j < BPW; j++) begin : g_byte
        logic [KW-1:0] w_idx;
        logic [7:0]    w_val;
        assign w_idx    = {widx, BPW_BITS'(j)};
        assign w_val    = word[NW-1-8*j -: 8];
        assign w_bad[j] = ((w_idx == len_bytes) && (w_val != 8'h80)) ||
                          ((w_idx >  len_bytes) && (w_val != 8'h00));
    end

    assign ok = ~|w_bad;

endmodule

`default_nettype wire

// File: rtl/sha_unpad.sv
// ============================================================================
// Module  : sha_unpad
// Brief   : Checks a padded SHA block and streams the original message bytes.
//           Define SHA_UNPAD_ERRCNT_EN to add the saturating Err_Count output.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sha_unpad
    import sha_unpad_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [NB-1:0] Data,
    input  logic          Enable,
    output logic          In_Ready,
    output logic [7:0]    Byte,
    output logic          Byte_Valid,
    input  logic          Byte_Ready,
    output logic [NM-1:0] Length,
    output logic          Done,
    output logic          Error
`ifdef SHA_UNPAD_ERRCNT_EN
    ,
    output logic [7:0]    Err_Count
`endif
);

    reg_type       r_reg;
    reg_type       w_next;
    logic [NW-1:0] w_word;
    logic [KW-1:0] w_len_bytes;
    logic          w_ok;

    assign w_word      = r_reg.block[32'(r_reg.w) * NW +: NW];
    // Upper length bits are known zero once LEN has accepted the block.
    assign w_len_bytes = r_reg.length[KW+2:3];

    sha_unpad_word_chk u_word_chk (
        .word      (w_word),
        .widx      (r_reg.w),
        .len_bytes (w_len_bytes),
        .ok        (w_ok)
    );

    always_comb begin
        w_next      = r_reg;
        w_next.done = 1'b0;
        case (r_reg.state)
            IDLE: begin
                if (Enable) begin
                    w_next.block    = Data;
                    w_next.error    = 1'b0;
                    w_next.in_ready = 1'b0;
                    w_next.state    = LEN;
                end
            end
            LEN: begin
                w_next.length = {r_reg.block[14*NW +: NW], r_reg.block[15*NW +: NW]};
                if ((w_next.length[2:0] != 3'd0) || ((w_next.length >> 3) > NM'(LMAX))) begin
                    w_next.state = ERR;
                    w_next.done  = 1'b1;
                    w_next.error = 1'b1;
                end else begin
                    w_next.state = CHECK;
                    w_next.w     = 4'd0;
                end
            end
            CHECK: begin
                if (!w_ok) begin
                    w_next.state = ERR;
                    w_next.done  = 1'b1;
                    w_next.error = 1'b1;
                end else if (r_reg.w == 4'd13) begin
                    if (w_len_bytes == '0) begin
                        w_next.state = DONE;
                        w_next.done  = 1'b1;
                    end else begin
                        w_next.state      = EMIT;
                        w_next.k          = '0;
                        w_next.msg_byte   = get_byte(r_reg.block, '0);
                        w_next.byte_valid = 1'b1;
                    end
                end else begin
                    w_next.w = r_reg.w + 4'd1;
                end
            end
            EMIT: begin
                if (Byte_Ready) begin
                    if (r_reg.k == w_len_bytes - KW'(1)) begin
                        w_next.state      = DONE;
                        w_next.byte_valid = 1'b0;
                        w_next.done       = 1'b1;
                    end else begin
                        w_next.k        = r_reg.k + KW'(1);
                        w_next.msg_byte = get_byte(r_reg.block, r_reg.k + KW'(1));
                    end
                end
            end
            DONE: begin
                w_next.state    = IDLE;
                w_next.in_ready = 1'b1;
            end
            ERR: begin
                w_next.state    = IDLE;
                w_next.in_ready = 1'b1;
`ifdef SHA_UNPAD_ERRCNT_EN
                if (r_reg.err_count != 8'hFF) begin
                    w_next.err_count = r_reg.err_count + 8'd1;
                end
`endif
            end
            default: begin
                w_next.state    = IDLE;
                w_next.in_ready = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_reg          <= '0;
            r_reg.state    <= IDLE;
            r_reg.in_ready <= 1'b1;
        end else begin
            r_reg <= w_next;
        end
    end

    assign In_Ready   = r_reg.in_ready;
    assign Byte       = r_reg.msg_byte;
    assign Byte_Valid = r_reg.byte_valid;
    assign Length     = r_reg.length;
    assign Done       = r_reg.done;
    assign Error      = r_reg.error;
`ifdef SHA_UNPAD_ERRCNT_EN
    assign Err_Count  = r_reg.err_count;
`endif

endmodule

`default_nettype wire
